pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and stall controller. It consumes the ID/EX register outputs (MemRead bit, rt) and the IF/ID
//  operand fields. It returns the write-enable and flush controls that drive PC, IF/ID, ID/EX and the
//  downstream pipeline registers. It inserts one bubble on load-use hazards and freezes the pipe during
//  dcache misses. It also keeps saturating stall statistics and a sticky miss-timeout flag.
// PARAMETERS
//  CNT_W    32    width of the statistics counters lu_cnt_o and mem_cnt_o
//  TIMEOUT  256   consecutive dcache-stall cycles that set timeout_o (must be >=1)
// PORTS
//  clk_i            in   1      clock, rising edge
//  rst_i            in   1      synchronous reset, active high
//  ifid_rs_i        in   5      rs field of the instruction in IF/ID
//  ifid_rt_i        in   5      rt field of the instruction in IF/ID
//  idex_memread_i   in   1      MemRead bit of the ID/EX M field (instruction in EX is a load)
//  idex_rt_i        in   5      rt (load destination) held in ID/EX
//  branch_taken_i   in   1      branch resolved taken in ID this cycle
//  dcache_stall_i   in   1      dcache miss in progress; level signal
//  pc_write_o       out  1      PC update enable
//  ifid_write_o     out  1      IF/ID load enable
//  ifid_flush_o     out  1      load NOP into IF/ID
//  idex_write_o     out  1      ID/EX load enable
//  idex_flush_o     out  1      zero the WB/M/EX control fields entering ID/EX (bubble)
//  pipe_write_o     out  1      EX/MEM and MEM/WB load enable
//  lu_cnt_o         out  CNT_W  number of load-use bubbles inserted, saturating
//  mem_cnt_o        out  CNT_W  number of dcache-stall cycles, saturating
//  timeout_o        out  1      sticky: one dcache stall lasted >= TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=RUN, lu_cnt_o=0, mem_cnt_o=0, run-length counter=0, timeout_o=0.
//   While rst_i is high, all *_write_o=1 and all *_flush_o=0.
//  lu_hit = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
//  Control outputs are combinational from state and inputs (zero latency). Priority: stall > load-use > branch.
//  States:
//   RUN
//    - If dcache_stall_i=1: all *_write_o=0, flushes=0; next state MEM_STALL.
//    - Else if lu_hit: pc_write_o=0, ifid_write_o=0, idex_flush_o=1, others write=1; next state LU_BUBBLE.
//    - Else if branch_taken_i: ifid_flush_o=1, all writes=1.
//    - Else: all writes=1, no flush.
//   LU_BUBBLE (exactly 1 cycle)
//    - lu_hit is masked, so at most one bubble is inserted per load.
//    - If dcache_stall_i=1: full freeze; next state MEM_STALL.
//    - Else: branch handled as in RUN; next state RUN.
//   MEM_STALL
//    - All *_write_o=0 and all *_flush_o=0 while dcache_stall_i=1.
//    - In the first cycle with dcache_stall_i=0: outputs are evaluated exactly as in RUN, in the same
//      cycle (hazard/branch re-checked on the frozen operands); next state as in RUN.
//  Branch coinciding with lu_hit: the bubble wins and ifid_flush_o=0. The branch re-resolves next cycle
//   with forwarded data.
//  Counters (registered, visible the cycle after the event):
//   - lu_cnt_o increments on every RUN->LU_BUBBLE transition.
//   - mem_cnt_o increments on every cycle sampled with dcache_stall_i=1.
//   - Both saturate at 2^CNT_W-1 and never wrap.
//  Timeout:
//   - The run-length counter clears on entry to MEM_STALL and increments each stalled cycle.
//   - It saturates at TIMEOUT.
//   - When it reaches TIMEOUT, timeout_o is set to 1 and stays 1 until reset.
//  Reset mid-stall: takes effect at the next posedge regardless of state; counters and flag clear.
// TESTING
//  1. Reset, then ld $2 in EX (memread=1, rt=2) with IF/ID rs=2 -> that cycle pc_write=0, ifid_write=0,
//     idex_flush=1; next cycle all writes=1; lu_cnt_o=1.
//  2. memread=1, rt=0, rs=0 -> no bubble; lu_cnt_o stays 0 (r0 exclusion).
//  3. dcache_stall_i high 5 cycles -> all writes=0 for exactly 5 cycles; mem_cnt_o=5; release cycle
//     writes=1.
//  4. lu_hit and branch_taken_i in the same cycle -> idex_flush=1, ifid_flush=0; branch alone next
//     cycle -> ifid_flush=1.
//  5. TIMEOUT=4: stall 3 cycles -> timeout_o=0. Then stall 4 cycles -> timeout_o=1, and it is still 1
//     after 10 idle cycles.
//  6. Assert rst_i during a stall while mem_cnt_o=7 -> next cycle state RUN, counters=0, timeout_o=0,
//     writes=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller: one bubble per load-use hazard, full freeze during dcache misses,
// saturating stall statistics and a sticky miss-timeout flag.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rt_i,
   input  logic             branch_taken_i,
   input  logic             dcache_stall_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_write_o,
   output logic             idex_flush_o,
   output logic             pipe_write_o,
   output logic [CNT_W-1:0] lu_cnt_o,
   output logic [CNT_W-1:0] mem_cnt_o,
   output logic             timeout_o
);

   localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RunMax = RUN_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   typedef enum logic [1:0] {StRun, StLuBubble, StMemStall} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               timeout_q, timeout_d;
   logic               lu_hit;
   logic               bubble;

   always_comb begin
      lu_hit = idex_memread_i & (idex_rt_i != 5'd0) &
               ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));

      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b0;
      idex_write_o = 1'b1;
      idex_flush_o = 1'b0;
      pipe_write_o = 1'b1;
      bubble       = 1'b0;
      state_d      = state_q;

      // MEM_STALL with the stall released decides exactly like RUN, in the same cycle.
      if (dcache_stall_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_write_o = 1'b0;
         pipe_write_o = 1'b0;
         state_d      = StMemStall;
      end else if (lu_hit && (state_q != StLuBubble)) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         idex_flush_o = 1'b1;
         bubble       = 1'b1;
         state_d      = StLuBubble;
      end else begin
         ifid_flush_o = branch_taken_i;
         state_d      = StRun;
      end

      if (rst_i) begin
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
         ifid_flush_o = 1'b0;
         idex_write_o = 1'b1;
         idex_flush_o = 1'b0;
         pipe_write_o = 1'b1;
      end

      lu_cnt_d = lu_cnt_q;
      if (bubble && (lu_cnt_q != CntMax)) begin
         lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end

      mem_cnt_d = mem_cnt_q;
      run_d     = run_q;
      if (dcache_stall_i) begin
         if (mem_cnt_q != CntMax) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
         end
         // The cycle that enters MEM_STALL is the first stalled cycle of this miss.
         if (state_q != StMemStall) begin
            run_d = RUN_W'(1);
         end else if (run_q != RunMax) begin
            run_d = run_q + RUN_W'(1);
         end
      end
      timeout_d = timeout_q | (run_d == RunMax);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StRun;
         lu_cnt_q  <= '0;
         mem_cnt_q <= '0;
         run_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lu_cnt_q  <= lu_cnt_d;
         mem_cnt_q <= mem_cnt_d;
         run_q     <= run_d;
         timeout_q <= timeout_d;
      end
   end

   assign lu_cnt_o  = lu_cnt_q;
   assign mem_cnt_o = mem_cnt_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vectors with literal expectations, plus a per-cycle
// comparison against an event-level model of the hazard rules.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMEOUT = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [4:0]       rs = '0, rt = '0, idrt = '0;
   logic             mr = 1'b0, br = 1'b0, st = 1'b0;
   logic             pc_w, ifid_w, ifid_f, idex_w, idex_f, pipe_w, tmo;
   logic [CNT_W-1:0] lu_cnt, mem_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ifid_rs_i      (rs),
      .ifid_rt_i      (rt),
      .idex_memread_i (mr),
      .idex_rt_i      (idrt),
      .branch_taken_i (br),
      .dcache_stall_i (st),
      .pc_write_o     (pc_w),
      .ifid_write_o   (ifid_w),
      .ifid_flush_o   (ifid_f),
      .idex_write_o   (idex_w),
      .idex_flush_o   (idex_f),
      .pipe_write_o   (pipe_w),
      .lu_cnt_o       (lu_cnt),
      .mem_cnt_o      (mem_cnt),
      .timeout_o      (tmo)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a load-use bubble is allowed unless the previous cycle already inserted one.
   logic m_valid = 1'b0;
   logic m_prev_bub = 1'b0;
   int   m_lu = 0, m_mem = 0, m_run = 0;
   logic m_to = 1'b0;

   always @(posedge clk) begin
      logic hit, bub;
      int   run_n;
      hit = mr && (idrt != 0) && ((idrt == rs) || (idrt == rt));
      if (rst) begin
         m_valid    <= 1'b1;
         m_prev_bub <= 1'b0;
         m_lu       <= 0;
         m_mem      <= 0;
         m_run      <= 0;
         m_to       <= 1'b0;
      end else begin
         bub = !st && hit && !m_prev_bub;
         m_prev_bub <= bub;
         if (bub && m_lu < CNT_MAX) m_lu <= m_lu + 1;
         if (st && m_mem < CNT_MAX) m_mem <= m_mem + 1;
         run_n = st ? m_run + 1 : 0;
         m_run <= run_n;
         if (run_n >= TIMEOUT) m_to <= 1'b1;
      end
   end

   always @(negedge clk) begin
      logic hit;
      logic e_pc, e_ifw, e_iff, e_idw, e_idf, e_pw;
      if (m_valid) begin
         hit = mr && (idrt != 0) && ((idrt == rs) || (idrt == rt));
         {e_pc, e_ifw, e_iff, e_idw, e_idf, e_pw} = 6'b110101;
         if (!rst) begin
            if (st) begin
               {e_pc, e_ifw, e_iff, e_idw, e_idf, e_pw} = 6'b000000;
            end else if (hit && !m_prev_bub) begin
               {e_pc, e_ifw, e_iff, e_idw, e_idf, e_pw} = 6'b000111;
            end else if (br) begin
               e_iff = 1'b1;
            end
         end
         check("mdl_pc_write", {31'd0, pc_w}, {31'd0, e_pc});
         check("mdl_ifid_write", {31'd0, ifid_w}, {31'd0, e_ifw});
         check("mdl_ifid_flush", {31'd0, ifid_f}, {31'd0, e_iff});
         check("mdl_idex_write", {31'd0, idex_w}, {31'd0, e_idw});
         check("mdl_idex_flush", {31'd0, idex_f}, {31'd0, e_idf});
         check("mdl_pipe_write", {31'd0, pipe_w}, {31'd0, e_pw});
         check("mdl_lu_cnt", 32'(lu_cnt), 32'(m_lu));
         check("mdl_mem_cnt", 32'(mem_cnt), 32'(m_mem));
         check("mdl_timeout", {31'd0, tmo}, {31'd0, m_to});
      end
   end

   // Drive one cycle of inputs just after the rising edge and return at the falling edge.
   task automatic apply(input logic a_rst, input logic [4:0] a_rs, input logic [4:0] a_rt,
                        input logic a_mr, input logic [4:0] a_idrt, input logic a_br,
                        input logic a_st);
      @(posedge clk);
      #1;
      rst = a_rst; rs = a_rs; rt = a_rt; mr = a_mr; idrt = a_idrt; br = a_br; st = a_st;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic stall(input int n);
      for (int i = 0; i < n; i++) begin
         apply(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
         check("stall_writes", {28'd0, pc_w, ifid_w, idex_w, pipe_w}, 32'd0);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      // Reset overrides a concurrent stall.
      apply(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("rst_writes", {28'd0, pc_w, ifid_w, idex_w, pipe_w}, 32'hF);
      apply(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      idle(1);
      check("rst_lu_cnt", 32'(lu_cnt), 32'd0);
      check("rst_mem_cnt", 32'(mem_cnt), 32'd0);
      check("rst_timeout", {31'd0, tmo}, 32'd0);

      // Load-use on rs: one bubble, then the held operands pass.
      apply(1'b0, 5'd2, 5'd5, 1'b1, 5'd2, 1'b0, 1'b0);
      check("lu_bubble", {27'd0, pc_w, ifid_w, idex_f, idex_w, pipe_w}, 32'b00111);
      apply(1'b0, 5'd2, 5'd5, 1'b1, 5'd2, 1'b0, 1'b0);
      check("lu_after", {27'd0, pc_w, ifid_w, idex_f, idex_w, pipe_w}, 32'b11011);
      check("lu_cnt_1", 32'(lu_cnt), 32'd1);

      // r0 is never a hazard.
      apply(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      check("r0_no_bubble", {30'd0, pc_w, idex_f}, 32'b10);
      idle(1);
      check("r0_lu_cnt", 32'(lu_cnt), 32'd1);

      // Bubble wins over branch; the branch alone flushes next cycle.
      apply(1'b0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
      check("lu_br_flush", {30'd0, idex_f, ifid_f}, 32'b10);
      apply(1'b0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
      check("br_flush", {30'd0, idex_f, ifid_f}, 32'b01);
      check("lu_cnt_2", 32'(lu_cnt), 32'd2);

      // Timeout: 3 stalled cycles are short of the limit, 4 reach it.
      idle(1);
      stall(3);
      idle(1);
      check("to_after3", {31'd0, tmo}, 32'd0);
      stall(4);
      idle(1);
      check("to_after4", {31'd0, tmo}, 32'd1);
      idle(10);
      check("to_sticky", {31'd0, tmo}, 32'd1);

      // Five stalled cycles, counted from a fresh reset; release re-checks the held hazard.
      apply(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      idle(1);
      stall(5);
      apply(1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
      check("release_bubble", {30'd0, pipe_w, idex_f}, 32'b11);
      check("mem_cnt_5", 32'(mem_cnt), 32'd5);
      idle(1);

      // Reset mid-stall at mem_cnt=7.
      stall(2);
      apply(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("mem_cnt_7", 32'(mem_cnt), 32'd7);
      apply(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("midrst_cnts", {27'd0, lu_cnt, tmo}, 32'd0);
      check("midrst_mem", 32'(mem_cnt), 32'd0);
      check("midrst_writes", {28'd0, pc_w, ifid_w, idex_w, pipe_w}, 32'hF);

      // Saturation of the stall counter.
      stall(20);
      idle(1);
      check("mem_cnt_sat", 32'(mem_cnt), 32'(CNT_MAX));
      check("to_long", {31'd0, tmo}, 32'd1);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
